// File: rtl/ecc_pkg.sv
// Shared helpers for the SEC-DED codec: code geometry functions and the error
// classification type.
package ecc_pkg;

  typedef enum logic [1:0] {ERR_NONE, ERR_SINGLE, ERR_DOUBLE} err_class_t;

  // Smallest R with 2^R >= data_w + R + 1.
  function automatic int calc_r(input int data_w);
    int r;
    r = 0;
    for (int k = 20; k >= 1; k--)
      if ((1 << k) >= data_w + k + 1) r = k;
    return r;
  endfunction

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Codeword position of data bit idx: the idx-th non-power-of-two position.
  function automatic int data_pos(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 3; p < idx + 64; p++) begin
      if (pos == 0 && !is_pow2(p)) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/ecc_syndrome_gen.sv
// Combinational Hamming check-bit generator; shared by the decoder and the
// future encoder.
module ecc_syndrome_gen
  import ecc_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int R      = calc_r(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  output logic [R-1:0]      check
);

  function automatic logic [DATA_W-1:0] cover_mask(input int b);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_W; i++)
      m[i] = ((data_pos(i) >> b) & 1) == 1;
    return m;
  endfunction

  for (genvar b = 0; b < R; b++) begin : g_chk
    localparam logic [DATA_W-1:0] MASK = cover_mask(b);
    assign check[b] = ^(data & MASK);
  end

endmodule

// File: rtl/ecc_secded_stream_dec.sv
// Two-stage streaming SEC-DED decoder with valid/ready flow control and
// saturating error counters. Define ECC_ERR_INJECT_EN to add the inj_mask port.
module ecc_secded_stream_dec
  import ecc_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int CNT_W  = 16,
  localparam int R      = calc_r(DATA_W),
  localparam int CHK_W  = R + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_check,
  input  logic              correct_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [R-1:0]      out_syndrome,
  output logic              out_err_single,
  output logic              out_err_double,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_single,
  output logic [CNT_W-1:0]  cnt_double
`ifdef ECC_ERR_INJECT_EN
  ,
  input  logic [DATA_W+CHK_W-1:0] inj_mask
`endif
);

  localparam int N = DATA_W + R;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W+CHK_W-1:0] rx;
  logic [DATA_W-1:0]       rx_data;
  logic [CHK_W-1:0]        rx_check;
  logic [R-1:0]            calc_check;

`ifdef ECC_ERR_INJECT_EN
  assign rx = {in_check, in_data} ^ inj_mask;
`else
  assign rx = {in_check, in_data};
`endif
  assign rx_data  = rx[DATA_W-1:0];
  assign rx_check = rx[DATA_W +: CHK_W];

  ecc_syndrome_gen #(.DATA_W(DATA_W)) u_syn (
    .data  (rx_data),
    .check (calc_check)
  );

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [R-1:0]      s1_syn;
  logic              s1_par;
  logic              s1_cen;
  logic              s2_advance;
  logic              out_hs;

  assign s2_advance = !out_valid || out_ready;
  // Gated by rst_n so the port reads 0 for the whole reset interval.
  assign in_ready   = rst_n && (!s1_valid || s2_advance);
  assign out_hs     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
      s1_cen   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= rx_data;
        s1_syn  <= calc_check ^ rx_check[R-1:0];
        s1_par  <= ^rx;
        s1_cen  <= correct_en;
      end
    end
  end

  logic [DATA_W-1:0] flip_mask;
  for (genvar i = 0; i < DATA_W; i++) begin : g_flip
    localparam logic [R-1:0] POS = R'(data_pos(i));
    assign flip_mask[i] = (s1_syn == POS);
  end

  err_class_t        cls;
  logic [DATA_W-1:0] fixed_data;
  logic              syn_pow2;

  // flip_mask is zero for syndromes at check positions or beyond N, so only
  // genuine data-position singles are altered.
  always_comb begin
    cls        = ERR_NONE;
    fixed_data = s1_data;
    syn_pow2   = (s1_syn & (s1_syn - R'(1))) == '0;
    if (!s1_par) begin
      if (s1_syn != '0) cls = ERR_DOUBLE;
    end else if (syn_pow2 || s1_syn <= R'(N)) begin
      cls = ERR_SINGLE;
      if (s1_cen) fixed_data = s1_data ^ flip_mask;
    end else begin
      cls = ERR_DOUBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_syndrome   <= '0;
      out_err_single <= 1'b0;
      out_err_double <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data       <= fixed_data;
        out_syndrome   <= s1_syn;
        out_err_single <= (cls == ERR_SINGLE);
        out_err_double <= (cls == ERR_DOUBLE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (cnt_clr) begin
      cnt_single <= (out_hs && out_err_single) ? CNT_ONE : '0;
      cnt_double <= (out_hs && out_err_double) ? CNT_ONE : '0;
    end else begin
      if (out_hs && out_err_single && cnt_single != CNT_MAX)
        cnt_single <= cnt_single + CNT_ONE;
      if (out_hs && out_err_double && cnt_double != CNT_MAX)
        cnt_double <= cnt_double + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_ecc_secded_stream_dec.sv
// Directed self-checking bench for ecc_secded_stream_dec; a second instance with
// CNT_W=4 shares the stimulus to exercise counter saturation.
module tb_ecc_secded_stream_dec;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [6:0]  in_check;
  logic        correct_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_syndrome;
  logic        out_err_single;
  logic        out_err_double;
  logic        cnt_clr;
  logic [15:0] cnt_single;
  logic [15:0] cnt_double;

  logic        in_ready4;
  logic        out_valid4;
  logic [31:0] out_data4;
  logic [5:0]  out_syndrome4;
  logic        out_err_single4;
  logic        out_err_double4;
  logic [3:0]  cnt_single4;
  logic [3:0]  cnt_double4;

  int tests;
  int fails;
  int exp_single;
  int exp_double;

  ecc_secded_stream_dec #(.DATA_W(32), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_check       (in_check),
    .correct_en     (correct_en),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_syndrome   (out_syndrome),
    .out_err_single (out_err_single),
    .out_err_double (out_err_double),
    .cnt_clr        (cnt_clr),
    .cnt_single     (cnt_single),
    .cnt_double     (cnt_double)
`ifdef ECC_ERR_INJECT_EN
    ,
    .inj_mask       ('0)
`endif
  );

  ecc_secded_stream_dec #(.DATA_W(32), .CNT_W(4)) dut4 (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready4),
    .in_data        (in_data),
    .in_check       (in_check),
    .correct_en     (correct_en),
    .out_valid      (out_valid4),
    .out_ready      (out_ready),
    .out_data       (out_data4),
    .out_syndrome   (out_syndrome4),
    .out_err_single (out_err_single4),
    .out_err_double (out_err_double4),
    .cnt_clr        (cnt_clr),
    .cnt_single     (cnt_single4),
    .cnt_double     (cnt_double4)
`ifdef ECC_ERR_INJECT_EN
    ,
    .inj_mask       ('0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one word on an idle pipeline and wait (bounded) for it at the output.
  task automatic xfer(input logic [31:0] d, input logic [6:0] c, input logic cen,
                      output bit ok, output int lat);
    @(posedge clk); #1;
    in_valid   = 1'b1;
    in_data    = d;
    in_check   = c;
    correct_en = cen;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ok  = 1'b0;
    lat = 0;
    for (int n = 0; n < 6 && !ok; n++) begin
      if (out_valid) ok = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_check = '0; correct_en = 1'b1;
    out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready);
    end
    tests++;
    if ({out_valid, out_data, out_syndrome, out_err_single, out_err_double} !== '0) begin
      fails++; $display("[TB] FAIL reset_outputs: got v=%b d=%h s=%0d f=%b%b want all 0",
                        out_valid, out_data, out_syndrome, out_err_single, out_err_double);
    end
    tests++;
    if (cnt_single !== 16'd0 || cnt_double !== 16'd0) begin
      fails++; $display("[TB] FAIL reset_counters: got %0d/%0d want 0/0", cnt_single, cnt_double);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_clean;
    bit ok; int lat;
    xfer(32'h0000_0000, 7'h00, 1'b1, ok, lat);
    tests++;
    if (!ok || lat !== 1) begin
      fails++; $display("[TB] FAIL clean_latency: got ok=%0d wait=%0d want ok=1 wait=1", ok, lat);
    end
    tests++;
    if (out_data !== 32'h0 || out_syndrome !== 6'd0 || out_err_single !== 1'b0 || out_err_double !== 1'b0) begin
      fails++; $display("[TB] FAIL clean_word: got d=%h s=%0d f=%b%b want d=0 s=0 f=00",
                        out_data, out_syndrome, out_err_single, out_err_double);
    end
  endtask

  task automatic test_single;
    bit ok; int lat;
    xfer(32'h0000_0001, 7'h00, 1'b1, ok, lat);
    exp_single++;
    tests++;
    if (!ok || out_data !== 32'h0 || out_syndrome !== 6'd3 || out_err_single !== 1'b1 || out_err_double !== 1'b0) begin
      fails++; $display("[TB] FAIL single_corrected: got ok=%0d d=%h s=%0d f=%b%b want d=0 s=3 f=10",
                        ok, out_data, out_syndrome, out_err_single, out_err_double);
    end
    xfer(32'h0000_0001, 7'h00, 1'b0, ok, lat);
    exp_single++;
    tests++;
    if (!ok || out_data !== 32'h1 || out_syndrome !== 6'd3 || out_err_single !== 1'b1 || out_err_double !== 1'b0) begin
      fails++; $display("[TB] FAIL single_no_correct: got ok=%0d d=%h s=%0d f=%b%b want d=1 s=3 f=10",
                        ok, out_data, out_syndrome, out_err_single, out_err_double);
    end
  endtask

  task automatic test_double;
    bit ok; int lat;
    xfer(32'h0000_0003, 7'h00, 1'b1, ok, lat);
    exp_double++;
    tests++;
    if (!ok || out_data !== 32'h3 || out_syndrome !== 6'd6 || out_err_single !== 1'b0 || out_err_double !== 1'b1) begin
      fails++; $display("[TB] FAIL double_word: got ok=%0d d=%h s=%0d f=%b%b want d=3 s=6 f=01",
                        ok, out_data, out_syndrome, out_err_single, out_err_double);
    end
  endtask

  task automatic test_check_errors;
    bit ok; int lat;
    xfer(32'h0, 7'b100_0000, 1'b1, ok, lat);
    exp_single++;
    tests++;
    if (!ok || out_data !== 32'h0 || out_syndrome !== 6'd0 || out_err_single !== 1'b1 || out_err_double !== 1'b0) begin
      fails++; $display("[TB] FAIL parity_bit_err: got ok=%0d d=%h s=%0d f=%b%b want d=0 s=0 f=10",
                        ok, out_data, out_syndrome, out_err_single, out_err_double);
    end
    xfer(32'h0, 7'b000_0100, 1'b1, ok, lat);
    exp_single++;
    tests++;
    if (!ok || out_data !== 32'h0 || out_syndrome !== 6'd4 || out_err_single !== 1'b1 || out_err_double !== 1'b0) begin
      fails++; $display("[TB] FAIL check_bit_err: got ok=%0d d=%h s=%0d f=%b%b want d=0 s=4 f=10",
                        ok, out_data, out_syndrome, out_err_single, out_err_double);
    end
  endtask

  task automatic test_boundary;
    bit ok; int lat;
    // data[31] sits at position 38 = N, the highest valid syndrome
    xfer(32'h8000_0001, 7'b100_0011, 1'b1, ok, lat);
    exp_single++;
    tests++;
    if (!ok || out_data !== 32'h1 || out_syndrome !== 6'd38 || out_err_single !== 1'b1 || out_err_double !== 1'b0) begin
      fails++; $display("[TB] FAIL syndrome_at_n: got ok=%0d d=%h s=%0d f=%b%b want d=1 s=38 f=10",
                        ok, out_data, out_syndrome, out_err_single, out_err_double);
    end
    xfer(32'h0, 7'b110_0111, 1'b1, ok, lat);
    exp_double++;
    tests++;
    if (!ok || out_data !== 32'h0 || out_syndrome !== 6'd39 || out_err_single !== 1'b0 || out_err_double !== 1'b1) begin
      fails++; $display("[TB] FAIL syndrome_above_n: got ok=%0d d=%h s=%0d f=%b%b want d=0 s=39 f=01",
                        ok, out_data, out_syndrome, out_err_single, out_err_double);
    end
    xfer(32'h0, 7'b111_1111, 1'b1, ok, lat);
    exp_double++;
    tests++;
    if (!ok || out_data !== 32'h0 || out_syndrome !== 6'd63 || out_err_single !== 1'b0 || out_err_double !== 1'b1) begin
      fails++; $display("[TB] FAIL syndrome_max: got ok=%0d d=%h s=%0d f=%b%b want d=0 s=63 f=01",
                        ok, out_data, out_syndrome, out_err_single, out_err_double);
    end
    xfer(32'h0000_0001, 7'b100_0011, 1'b1, ok, lat);
    tests++;
    if (!ok || out_data !== 32'h1 || out_syndrome !== 6'd0 || out_err_single !== 1'b0 || out_err_double !== 1'b0) begin
      fails++; $display("[TB] FAIL encoded_clean: got ok=%0d d=%h s=%0d f=%b%b want d=1 s=0 f=00",
                        ok, out_data, out_syndrome, out_err_single, out_err_double);
    end
  endtask

  task automatic test_counters;
    @(posedge clk); #1;
    tests++;
    if (cnt_single !== 16'(exp_single) || cnt_double !== 16'(exp_double)) begin
      fails++; $display("[TB] FAIL counters: got %0d/%0d want %0d/%0d", cnt_single, cnt_double, exp_single, exp_double);
    end
    tests++;
    if (cnt_single4 !== 4'(exp_single) || cnt_double4 !== 4'(exp_double)) begin
      fails++; $display("[TB] FAIL counters_w4: got %0d/%0d want %0d/%0d", cnt_single4, cnt_double4, exp_single, exp_double);
    end
  endtask

  task automatic test_saturation;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'h1; in_check = 7'h00; correct_en = 1'b1; out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_single += 20;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (cnt_single4 !== 4'd15) begin
      fails++; $display("[TB] FAIL saturate_w4: got %0d want 15", cnt_single4);
    end
    tests++;
    if (cnt_single !== 16'(exp_single)) begin
      fails++; $display("[TB] FAIL count_w16: got %0d want %0d", cnt_single, exp_single);
    end
    tests++;
    if (cnt_double4 !== 4'(exp_double)) begin
      fails++; $display("[TB] FAIL double_w4_hold: got %0d want %0d", cnt_double4, exp_double);
    end
  endtask

  task automatic test_clear;
    bit ok; int lat;
    xfer(32'h0000_0001, 7'h00, 1'b1, ok, lat);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    exp_single = 1;
    exp_double = 0;
    tests++;
    if (!ok || cnt_single !== 16'd1 || cnt_single4 !== 4'd1) begin
      fails++; $display("[TB] FAIL clear_with_event: got ok=%0d %0d/%0d want 1/1", ok, cnt_single, cnt_single4);
    end
    tests++;
    if (cnt_double !== 16'd0 || cnt_double4 !== 4'd0) begin
      fails++; $display("[TB] FAIL clear_double: got %0d/%0d want 0/0", cnt_double, cnt_double4);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w [4];
    logic [31:0] got [$];
    logic [31:0] held;
    logic        stalled;
    int          acc;
    w[0] = 32'hA5A5_0001; w[1] = 32'h5A5A_0002; w[2] = 32'h1234_5678; w[3] = 32'hDEAD_BEEF;
    acc = 0;
    stalled = 1'b0;
    held = '0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (stalled) begin
        tests++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          fails++; $display("[TB] FAIL stall_stable: got v=%b d=%h want v=1 d=%h", out_valid, out_data, held);
        end
      end
      out_ready = (c >= 5);
      if (acc < 4) begin
        in_valid = 1'b1; in_data = w[acc]; in_check = 7'h00; correct_en = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      if (c == 3) begin
        tests++;
        if (in_ready !== 1'b0 || acc !== 2) begin
          fails++; $display("[TB] FAIL stall_in_ready: got ready=%b accepted=%0d want ready=0 accepted=2", in_ready, acc);
        end
      end
      @(negedge clk);
      stalled = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) got.push_back(out_data);
      if (in_valid && in_ready) acc++;
    end
    in_valid = 1'b0;
    tests++;
    if (got.size() !== 4) begin
      fails++; $display("[TB] FAIL burst_count: got %0d words want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (got[i] !== w[i]) begin
          fails++; $display("[TB] FAIL burst_order[%0d]: got %h want %h", i, got[i], w[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'h3; in_check = 7'h00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_valid4 !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL midreset_valid: got out_valid=%b/%b in_ready=%b want 0/0/0", out_valid, out_valid4, in_ready);
    end
    tests++;
    if (cnt_single !== 16'd0 || cnt_double !== 16'd0 || cnt_single4 !== 4'd0 || cnt_double4 !== 4'd0) begin
      fails++; $display("[TB] FAIL midreset_counters: got %0d/%0d/%0d/%0d want 0", cnt_single, cnt_double, cnt_single4, cnt_double4);
    end
    tests++;
    if (out_data !== 32'h0 || out_syndrome !== 6'd0 || out_err_single !== 1'b0 || out_err_double !== 1'b0) begin
      fails++; $display("[TB] FAIL midreset_outputs: got d=%h s=%0d f=%b%b want 0", out_data, out_syndrome, out_err_single, out_err_double);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL midreset_ready_after: got %b want 1", in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL midreset_discard: got out_valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_single = 0;
    exp_double = 0;
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_check_errors();
    test_boundary();
    test_counters();
    test_saturation();
    test_clear();
    test_back_to_back();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ecc_secded_stream_dec.md
Name: ecc_secded_stream_dec

Overview:
- Pipelined, parametrised SEC-DED (Hamming + overall parity) decoder for streamed words; successor to the fixed 32-bit combinational single-error corrector.
- Adds generic data width, double-error detection, valid/ready flow control, a correction enable, and saturating error-statistics counters.
- Sits between storage/link receive logic and the consumer datapath.

Parameters:
- DATA_W, 32, data bits per word (>=4).
- R, derived localparam: minimal R with 2^R >= DATA_W+R+1 (6 for DATA_W=32).
- CHK_W, derived localparam: R+1 (7 for DATA_W=32).
- CNT_W, 16, width of each error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input word valid.
- in_ready  out  1  decoder can accept the input word.
- in_data  in  DATA_W  received data.
- in_check  in  CHK_W  received check bits; [R-1:0] Hamming, [R] overall parity.
- correct_en  in  1  when 1, single data-bit errors are corrected; when 0, data passes unmodified. Classification is unaffected.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  DATA_W  corrected or raw data.
- out_syndrome  out  R  Hamming syndrome of this word.
- out_err_single  out  1  correctable error flagged.
- out_err_double  out  1  uncorrectable error flagged.
- cnt_clr  in  1  synchronous clear of both counters.
- cnt_single  out  CNT_W  saturating count of single errors.
- cnt_double  out  CNT_W  saturating count of double errors.

Behaviour:
- Code layout:
  - Codeword positions 1..N, with N = DATA_W+R.
  - Check bit i sits at position 2^i.
  - Data bits fill the non-power-of-two positions in ascending order; data[0] is at position 3.
  - Check i = XOR of data bits whose position has bit i set.
  - in_check[R] = even parity over all data and Hamming check bits.
- Stage 1 (S1): registers data, syndrome s = recomputed XOR received (R bits), overall mismatch P, and correct_en.
- Stage 2 (S2): classifies, corrects, and drives the outputs.
- Latency: 2 cycles from input handshake to out_valid when not stalled. Sustained throughput is 1 word/cycle.
- Flow control:
  - Each stage advances when it is empty or its downstream consumes.
  - in_ready = !S1_valid || S2_advance. This path is combinational from out_ready; no skid buffer.
  - While out_valid && !out_ready, all out_* signals hold stable.
- Classification:
  - s==0, P==0: clean.
  - P==1, s==0: single; the error is in the overall parity bit and data is unchanged.
  - P==1, s is a check position: single; data unchanged.
  - P==1, s is a data position <= N: single; that data bit is flipped iff correct_en.
  - P==1, s > N: double (invalid syndrome); data raw.
  - P==0, s!=0: double; data raw.
- out_err_single and out_err_double are never both 1.
- Counters:
  - Increment on output handshake (out_valid && out_ready) when the matching flag is set.
  - Saturate at 2^CNT_W-1.
  - cnt_clr has priority. If clear coincides with a counted event, the counter loads 1.
- Reset (async assert, any time including mid-stream):
  - in_ready=0 during reset, 1 the first cycle after.
  - out_valid=0; out_data, out_syndrome and flags all 0; counters 0.
  - In-flight words are discarded.
- Release of rst_n is synchronised externally.

Optional Feature:
- Macro: ECC_ERR_INJECT_EN.
- Defined:
  - Adds input port inj_mask [DATA_W+CHK_W-1:0].
  - Concatenation order {check, data}; data is bits [DATA_W-1:0].
  - The mask is XORed onto {in_check,in_data} at the input handshake, before syndrome computation, for verification and fault campaigns.
- Undefined: the port is absent and there is zero injection logic.

Decomposition:
- Shared package ecc_pkg:
  - Function computing R from DATA_W.
  - Function mapping data index to codeword position.
  - is_pow2 helper.
  - Enum err_class_t {ERR_NONE, ERR_SINGLE, ERR_DOUBLE}.
- Sub-module ecc_syndrome_gen (purely combinational, parametrised on DATA_W).
  - Reused by the future encoder to generate check bits.

Test Plan:
- Clean word: data=0x00000000, check=0 -> out_data 0x00000000, syndrome 0, both flags 0, latency 2.
- Single data error: data=0x00000001, check=0, correct_en=1 -> out_data 0x00000000, syndrome 6'd3, single=1. Same word with correct_en=0 -> out_data 0x00000001, single=1.
- Double error: data=0x00000003, check=0 -> syndrome 6'd6, double=1, out_data 0x00000003, cnt_double +1.
- Parity-bit-only error: data=0, check=7'b1000000 -> syndrome 0, single=1, data 0.
- Backpressure: hold out_ready=0 for 5 cycles during a 4-word burst -> no loss/duplication; outputs stable; in_ready drops after 2 words buffered.
- CNT_W=4 run:
  - 20 single-error words -> cnt_single=15.
  - cnt_clr concurrent with a single -> cnt_single=1.
  - rst_n pulse mid-burst -> out_valid=0 and counters 0 immediately.
